da_sample_scheduler: RTL and testbench

- Sequencer in front of the distributed-arithmetic FIR datapath `da`: 8 partitions × 8 taps = 64-tap filter, 16-bit two's-complement samples.
- Owns the coefficient-load port (CLOAD/CIN/CADDR) and a 64-deep sample delay line.
- Per accepted sample: clears the DA accumulator, then issues 16 bit-serial start/done iterations, MSB first, building the eight 8-bit partition addresses each iteration.
- Captures ACC_OUT as the filter output and presents it on a valid/ready handshake.

---
 rtl/da_sample_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_da_sample_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_sample_scheduler.sv
// da_sample_scheduler
// Sequencer in front of the distributed-arithmetic FIR datapath "da"
// (8 partitions x 8 taps = 64 taps, XW-bit two's-complement samples).
// Owns the coefficient-load port and a 64-deep sample delay line. For each
// accepted sample it clears the DA accumulator, runs XW bit-serial
// start/done iterations MSB first, then captures da_acc as the filter output.
//
// Optional feature macro: DA_TIMEOUT_EN (watchdog on da_done, sticky err).
//
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   coef_valid/ready/addr/data: coefficient write request (ROM word)
//   x_valid/ready/data        : input sample handshake
//   y_valid/ready/data        : filter output handshake
//   da_start, da_done, da_acc : per-iteration handshake and ACC_OUT of da
//   da_acc_clr                : drives da reset (clears ACC and bit counter)
//   da_resetn                 : ~reset, combinational
//   da_addr                   : {A7..A0}, A_p = da_addr[8p+7:8p]
//   da_cload/cin/caddr        : coefficient load port of da
//   busy                      : sequencer not idle
//   err                       : sticky watchdog error (0 without the macro)
module da_sample_scheduler #(
  parameter int unsigned XW       = 16,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned COEF_GAP = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coef_valid,
  output logic          coef_ready,
  input  logic [10:0]   coef_addr,
  input  logic [18:0]   coef_data,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [XW-1:0] x_data,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [38:0]   y_data,
  output logic          da_start,
  input  logic          da_done,
  input  logic [38:0]   da_acc,
  output logic          da_acc_clr,
  output logic          da_resetn,
  output logic [63:0]   da_addr,
  output logic          da_cload,
  output logic [18:0]   da_cin,
  output logic [10:0]   da_caddr,
  output logic          busy,
  output logic          err
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_GAP   = 4'd1;
  localparam logic [3:0] S_CLR   = 4'd2;
  localparam logic [3:0] S_ADDR  = 4'd3;
  localparam logic [3:0] S_START = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_SET   = 4'd6;
  localparam logic [3:0] S_CAP   = 4'd7;
  localparam logic [3:0] S_OUT   = 4'd8;

  localparam int unsigned TAPS = 64;
  localparam int unsigned BW   = $clog2(XW);
  // One shared counter serves GAP, WAIT and SET; sized for the longest count.
  localparam int unsigned CW   = $clog2(TIMEOUT + COEF_GAP + SETTLE + 1);

  logic [3:0]    state;
  logic [XW-1:0] dline [TAPS];
  logic [BW-1:0] bit_idx;
  logic [CW-1:0] cnt;
  logic [63:0]   addr_next;
  logic          coef_take;
  logic          x_take;
  logic          wait_expired;

  assign busy       = (state != S_IDLE);
  assign coef_ready = (state == S_IDLE);
  assign x_ready    = (state == S_IDLE) && !coef_valid;
  assign coef_take  = coef_valid && coef_ready;
  assign x_take     = x_valid && x_ready;
  assign da_resetn  = ~reset;

  // Bit slice b of every tap: A_p bit j comes from tap 8p+j.
  always_comb begin
    addr_next = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      addr_next[k] = dline[k][bit_idx];
    end
  end

`ifdef DA_TIMEOUT_EN
  assign wait_expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == S_WAIT && !da_done && wait_expired) begin
      err <= 1'b1;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign err          = 1'b0;
`endif

  // da_addr is registered in ADDR and da_start in START, so the address is
  // already stable during the cycle before the da_start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      for (int unsigned k = 0; k < TAPS; k++) begin
        dline[k] <= '0;
      end
      y_data     <= '0;
      y_valid    <= 1'b0;
      da_addr    <= '0;
      da_cin     <= '0;
      da_caddr   <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      da_start   <= 1'b0;
      da_cload   <= 1'b0;
      da_acc_clr <= 1'b0;
    end else begin
      da_start   <= 1'b0;
      da_cload   <= 1'b0;
      da_acc_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (coef_take) begin
            da_cload <= 1'b1;
            da_caddr <= coef_addr;
            da_cin   <= coef_data;
            cnt      <= '0;
            state    <= S_GAP;
          end else if (x_take) begin
            for (int unsigned k = 1; k < TAPS; k++) begin
              dline[k] <= dline[k-1];
            end
            dline[0] <= x_data;
            state    <= S_CLR;
          end
        end
        S_GAP: begin
          if (cnt == CW'(COEF_GAP - 1)) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CLR: begin
          da_acc_clr <= 1'b1;
          bit_idx    <= BW'(XW - 1);
          state      <= S_ADDR;
        end
        S_ADDR: begin
          da_addr <= addr_next;
          state   <= S_START;
        end
        S_START: begin
          da_start <= 1'b1;
          cnt      <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (da_done) begin
            cnt   <= '0;
            state <= S_SET;
          end else if (wait_expired) begin
            // Abandon the sample; its delay-line shift is kept.
            da_acc_clr <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SET: begin
          if (cnt == CW'(SETTLE - 1)) begin
            if (bit_idx == '0) begin
              state <= S_CAP;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              state   <= S_ADDR;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAP: begin
          y_data  <= da_acc;
          y_valid <= 1'b1;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da_sample_scheduler.sv
// Testbench for da_sample_scheduler: directed table-driven sample vectors
// plus hand-written sequences for coefficient load, backpressure, delay-line
// order, collision, mid-operation reset and (with DA_TIMEOUT_EN) watchdog.
// The DA stand-in answers da_start with da_done 3 cycles later and builds
// ACC = 2*ACC + popcount(da_addr), so the final ACC equals the unsigned sum
// of all 64 delay-line taps.
module tb_da_sample_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        coef_valid;
  logic        coef_ready;
  logic [10:0] coef_addr;
  logic [18:0] coef_data;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] x_data;
  logic        y_valid;
  logic        y_ready;
  logic [38:0] y_data;
  logic        da_start;
  logic        da_done;
  logic [38:0] da_acc;
  logic        da_acc_clr;
  logic        da_resetn;
  logic [63:0] da_addr;
  logic        da_cload;
  logic [18:0] da_cin;
  logic [10:0] da_caddr;
  logic        busy;
  logic        err;

  da_sample_scheduler #(.XW(16), .SETTLE(2), .COEF_GAP(2), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .da_start(da_start), .da_done(da_done), .da_acc(da_acc),
    .da_acc_clr(da_acc_clr), .da_resetn(da_resetn), .da_addr(da_addr),
    .da_cload(da_cload), .da_cin(da_cin), .da_caddr(da_caddr),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DA datapath stand-in.
  logic        done_en = 1'b1;
  logic [1:0]  dcnt;
  logic [38:0] acc;
  int          start_cnt = 0;
  logic [63:0] addr_log [2048];
  assign da_acc = acc;

  always @(posedge clk) begin
    if (reset) begin
      dcnt    <= '0;
      da_done <= 1'b0;
      acc     <= '0;
    end else begin
      if (da_start) begin
        dcnt <= 2'd2;
        addr_log[start_cnt % 2048] <= da_addr;
        start_cnt <= start_cnt + 1;
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1'b1;
      end
      da_done <= done_en && !da_start && (dcnt == 2'd1);
      if (da_acc_clr) acc <= '0;
      else if (da_done) acc <= {acc[37:0], 1'b0} + 39'($countones(da_addr));
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a sample and return the cycle in which it was accepted.
  task automatic send_sample(input logic [15:0] x, output int acc_c);
    int n;
    x_valid = 1'b1;
    x_data  = x;
    #1;
    n = 0;
    while (!x_ready && n < 500) begin
      tick;
      #1;
      n++;
    end
    if (!x_ready) chk("x_ready_timeout", 0, 1);
    acc_c = cyc;
    tick;
    x_valid = 1'b0;
  endtask

  // Wait for y_valid; returns latency from acceptance and the output word.
  task automatic wait_y(input int acc_c, output int lat, output logic [38:0] y);
    int n;
    n = 0;
    while (!y_valid && n < 3000) begin
      tick;
      n++;
    end
    if (!y_valid) chk("y_valid_timeout", 0, 1);
    lat = cyc - acc_c;
    y   = y_data;
  endtask

  task automatic take_y;
    y_ready = 1'b1;
    tick;
    y_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] x;
    logic [63:0] addr_b15;
    logic [63:0] addr_b0;
    logic [38:0] y;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int          acc_c, lat, base, n, pulses;
    logic [38:0] y;
    logic        ok;

    tbl[0] = '{x: 16'h0001, addr_b15: 64'h0, addr_b0: 64'h1, y: 39'h00001};
    tbl[1] = '{x: 16'h8000, addr_b15: 64'h1, addr_b0: 64'h2, y: 39'h08001};
    tbl[2] = '{x: 16'hFFFF, addr_b15: 64'h3, addr_b0: 64'h5, y: 39'h18000};
    tbl[3] = '{x: 16'h0003, addr_b15: 64'h6, addr_b0: 64'hB, y: 39'h18003};

    reset = 1'b1; coef_valid = 1'b0; coef_addr = '0; coef_data = '0;
    x_valid = 1'b0; x_data = '0; y_ready = 1'b0;

    // Reset values.
    repeat (3) tick;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_da_start", da_start, 0);
    chk("rst_da_addr", da_addr, 0);
    chk("rst_da_cload", da_cload, 0);
    chk("rst_da_acc_clr", da_acc_clr, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_da_resetn", da_resetn, 0);
    reset = 1'b0;
    tick;
    chk("rst_coef_ready", coef_ready, 1);
    chk("rst_x_ready", x_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_da_resetn_rel", da_resetn, 1);

    // Coefficient load.
    coef_valid = 1'b1; coef_addr = 11'h005; coef_data = 19'h00123;
    tick;
    coef_valid = 1'b0;
    chk("cload_pulse", da_cload, 1);
    chk("cload_caddr", da_caddr, 64'h005);
    chk("cload_cin", da_cin, 64'h00123);
    chk("cload_ready_lo1", coef_ready, 0);
    tick;
    chk("cload_end", da_cload, 0);
    chk("cload_ready_lo2", coef_ready, 0);
    tick;
    chk("cload_ready_hi", coef_ready, 1);

    // Table-driven samples.
    for (int i = 0; i < 4; i++) begin
      base = start_cnt;
      send_sample(tbl[i].x, acc_c);
      wait_y(acc_c, lat, y);
      chk($sformatf("vec%0d_latency", i), lat, 131);
      chk($sformatf("vec%0d_y", i), y, tbl[i].y);
      chk($sformatf("vec%0d_starts", i), start_cnt - base, 16);
      chk($sformatf("vec%0d_addr_b15", i), addr_log[base % 2048], tbl[i].addr_b15);
      chk($sformatf("vec%0d_addr_b0", i), addr_log[(base + 15) % 2048], tbl[i].addr_b0);
      take_y;
    end

    // Backpressure.
    send_sample(16'h0100, acc_c);
    wait_y(acc_c, lat, y);
    chk("bp_y_first", y, 39'h18103);
    x_valid = 1'b1; x_data = 16'hAAAA;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      #1;
      if (!y_valid || y_data !== y || x_ready) ok = 1'b0;
    end
    chk("bp_hold_stable", ok, 1);
    x_valid = 1'b0;
    take_y;
    chk("bp_y_valid_fall", y_valid, 0);
    chk("bp_x_ready_back", x_ready, 1);

    // Delay-line order: fresh line, 65 samples 0x0001..0x0041.
    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    tick;
    for (int i = 1; i <= 65; i++) begin
      base = start_cnt;
      send_sample(16'(i), acc_c);
      wait_y(acc_c, lat, y);
      take_y;
    end
    chk("order_addr_b0", addr_log[(base + 15) % 2048], 64'h5555_5555_5555_5555);
    chk("order_addr_b15", addr_log[base % 2048], 64'h0);
    chk("order_y", y, 39'h860);

    // Reset during bit 7 (ninth iteration).
    base = start_cnt;
    send_sample(16'h00FF, acc_c);
    n = 0;
    while (start_cnt < base + 9 && n < 500) begin
      tick;
      n++;
    end
    chk("rst_mid_reached", start_cnt - base, 9);
    reset = 1'b1;
    tick;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_da_addr", da_addr, 0);
    chk("rst_mid_da_start", da_start, 0);
    chk("rst_mid_y_valid", y_valid, 0);
    reset = 1'b0;
    tick;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (y_valid || !x_ready || !coef_ready) ok = 1'b0;
      tick;
    end
    chk("rst_mid_quiet", ok, 1);
    base = start_cnt;
    send_sample(16'h0007, acc_c);
    wait_y(acc_c, lat, y);
    chk("rst_mid_line_cleared", y, 39'h7);
    chk("rst_mid_addr_b0", addr_log[(base + 15) % 2048], 64'h1);
    take_y;

    // Collision: coefficient first, sample after the gap.
    coef_valid = 1'b1; coef_addr = 11'h7FF; coef_data = 19'h5A5A5;
    x_valid = 1'b1; x_data = 16'h0010;
    #1;
    chk("coll_x_ready_lo", x_ready, 0);
    tick;
    coef_valid = 1'b0;
    #1;
    chk("coll_cload", da_cload, 1);
    chk("coll_caddr", da_caddr, 64'h7FF);
    n = 0;
    while (!x_ready && n < 20) begin
      tick;
      #1;
      n++;
    end
    chk("coll_gap_cycles", n, 2);
    acc_c = cyc;
    tick;
    x_valid = 1'b0;
    wait_y(acc_c, lat, y);
    chk("coll_latency", lat, 131);
    chk("coll_y", y, 39'h17);
    take_y;

    // Held coef_valid: one write per gap period.
    coef_valid = 1'b1; coef_addr = 11'h001; coef_data = 19'h00001;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (da_cload) pulses++;
      if (i == 6) coef_valid = 1'b0;
    end
    chk("held_coef_pulses", pulses, 3);

`ifdef DA_TIMEOUT_EN
    done_en = 1'b0;
    send_sample(16'h0001, acc_c);
    n = 0;
    while (!da_start && n < 50) begin
      tick;
      n++;
    end
    base = cyc;
    n = 0;
    while (busy && n < 1000) begin
      tick;
      n++;
    end
    chk("to_cycles", cyc - base, 255);
    chk("to_err", err, 1);
    chk("to_no_y", y_valid, 0);
    repeat (5) tick;
    chk("to_err_sticky", err, 1);
    done_en = 1'b1;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    chk("to_err_cleared", err, 0);
`else
    chk("err_tied_low", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
